// File: rtl/turn_sequencer.sv
// Player/enemy turn controller feeding the enemy renderer, with a frame watchdog on the enemy turn.
// Optional TURN_TIMER_EN: the player turn auto-commits after PLAYER_FRAMES frames.
module turn_sequencer #(
  parameter int MAX_TURNS      = 10,
  parameter int TIMEOUT_FRAMES = 120
`ifdef TURN_TIMER_EN
  , parameter int PLAYER_FRAMES = 300
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_btn_in,
  input  logic       rotate_btn_in,
  input  logic       commit_btn_in,
  input  logic       new_frame_in,
  input  logic       enemy_busy_in,
  input  logic       enemy_finished_in,
  output logic [3:0] state_out,
  output logic [3:0] turn_out,
  output logic [1:0] rotate_out,
  output logic       start_out,
  output logic       game_over_out,
  output logic       timeout_out
);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_PLAYER    = 4'd1,
    S_EN_START  = 4'd2,
    S_EN_WAIT   = 4'd3,
    S_RESOLVE   = 4'd4,
    S_GAME_OVER = 4'd5
  } state_t;

  localparam logic [3:0] LAST_TURN = 4'(MAX_TURNS - 1);
  localparam logic [8:0] TO_LIM    = 9'(TIMEOUT_FRAMES);
`ifdef TURN_TIMER_EN
  localparam logic [8:0] PL_LIM    = 9'(PLAYER_FRAMES);
`endif

  state_t     state, nxt;
  logic [3:0] turn_q, turn_n;
  logic [1:0] rot_q, rot_n;
  logic       start_q, start_n;
  logic       go_q, go_n;
  logic       to_q, to_n;
  logic [8:0] cnt_q, cnt_n, cnt_inc;
  logic       commit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      turn_q  <= '0;
      rot_q   <= '0;
      start_q <= 1'b0;
      go_q    <= 1'b0;
      to_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state   <= nxt;
      turn_q  <= turn_n;
      rot_q   <= rot_n;
      start_q <= start_n;
      go_q    <= go_n;
      to_q    <= to_n;
      cnt_q   <= cnt_n;
    end
  end

  always_comb begin
    nxt     = state;
    turn_n  = turn_q;
    rot_n   = rot_q;
    start_n = 1'b0;
    go_n    = 1'b0;
    to_n    = to_q;
    cnt_n   = cnt_q;
    commit  = commit_btn_in;
    // Saturating frame count shared by the watchdog and the optional player timer.
    cnt_inc = (cnt_q == 9'h1FF) ? cnt_q : cnt_q + 9'd1;
    case (state)
      S_IDLE: begin
        if (start_btn_in) begin
          nxt   = S_PLAYER;
          cnt_n = '0;
        end
      end
      S_PLAYER: begin
        if (rotate_btn_in) rot_n = rot_q + 2'd1;
`ifdef TURN_TIMER_EN
        if (new_frame_in) begin
          cnt_n = cnt_inc;
          if (cnt_inc >= PL_LIM) commit = 1'b1;
        end
`endif
        if (commit) nxt = S_EN_START;
      end
      S_EN_START: begin
        if (!enemy_busy_in) begin
          start_n = 1'b1;
          cnt_n   = '0;
          nxt     = S_EN_WAIT;
        end
      end
      S_EN_WAIT: begin
        // A finish on the timeout frame wins and leaves the sticky flag untouched.
        if (enemy_finished_in) begin
          nxt = S_RESOLVE;
        end else if (new_frame_in) begin
          cnt_n = cnt_inc;
          if (cnt_inc >= TO_LIM) begin
            to_n = 1'b1;
            nxt  = S_RESOLVE;
          end
        end
      end
      S_RESOLVE: begin
        if (turn_q == LAST_TURN) begin
          go_n = 1'b1;
          nxt  = S_GAME_OVER;
        end else begin
          turn_n = turn_q + 4'd1;
          cnt_n  = '0;
          nxt    = S_PLAYER;
        end
      end
      S_GAME_OVER: begin
        go_n = 1'b1;
        if (start_btn_in) begin
          go_n   = 1'b0;
          turn_n = '0;
          rot_n  = '0;
          to_n   = 1'b0;
          cnt_n  = '0;
          nxt    = S_PLAYER;
        end
      end
      default: nxt = S_IDLE;
    endcase
  end

  assign state_out     = state;
  assign turn_out      = turn_q;
  assign rotate_out    = rot_q;
  assign start_out     = start_q;
  assign game_over_out = go_q;
  assign timeout_out   = to_q;

endmodule

// File: tb/tb_turn_sequencer.sv
// Directed bench for turn_sequencer: stimulus queues expected output snapshots, a monitor
// compares them against every observed output change.
module tb_turn_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn, rotate_btn, commit_btn, new_frame, enemy_busy, enemy_finished;
  logic [3:0] state_out, turn_out;
  logic [1:0] rotate_out;
  logic       start_out, game_over_out, timeout_out;

  typedef struct {
    string       name;
    logic [12:0] val;
  } exp_t;

  exp_t        exp_q[$];
  int          total = 0;
  int          bad   = 0;
  logic        mon_en = 1'b0;
  logic [12:0] last;

  turn_sequencer dut (
    .clk              (clk),
    .rst              (rst),
    .start_btn_in     (start_btn),
    .rotate_btn_in    (rotate_btn),
    .commit_btn_in    (commit_btn),
    .new_frame_in     (new_frame),
    .enemy_busy_in    (enemy_busy),
    .enemy_finished_in(enemy_finished),
    .state_out        (state_out),
    .turn_out         (turn_out),
    .rotate_out       (rotate_out),
    .start_out        (start_out),
    .game_over_out    (game_over_out),
    .timeout_out      (timeout_out)
  );

  always #5 clk = ~clk;

  function automatic logic [12:0] cur_out();
    return {state_out, turn_out, rotate_out, start_out, game_over_out, timeout_out};
  endfunction

  // Expected snapshot: state, turn, rotate, start, game_over, timeout.
  function automatic void push(string n, int s, int t, int r, int st, int g, int to);
    exp_t e;
    e.name = n;
    e.val  = {4'(s), 4'(t), 2'(r), 1'(st), 1'(g), 1'(to)};
    exp_q.push_back(e);
  endfunction

  always @(negedge clk) begin
    if (mon_en) begin
      logic [12:0] c;
      exp_t        e;
      c = cur_out();
      if (c !== last) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_change got=%h last=%h", c, last);
        end else begin
          e = exp_q.pop_front();
          if (c !== e.val) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", e.name, c, e.val);
          end
        end
        last = c;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic play_turn(int t, int r, int to);
    commit_btn = 1'b1;
    push("commit", 2, t, r, 0, 0, to);
    cyc(1);
    commit_btn = 1'b0;
    push("launch", 3, t, r, 1, 0, to);
    push("launch_end", 3, t, r, 0, 0, to);
    cyc(3);
    enemy_finished = 1'b1;
    push("resolve", 4, t, r, 0, 0, to);
    if (t == 9) push("game_over", 5, t, r, 0, 1, to);
    else        push("next_turn", 1, t + 1, r, 0, 0, to);
    cyc(1);
    enemy_finished = 1'b0;
    cyc(2);
  endtask

  initial begin
    rst = 1'b0;
    {start_btn, rotate_btn, commit_btn, new_frame, enemy_busy, enemy_finished} = '0;
    #22;
    total++;
    if (cur_out() !== 13'h0) begin
      bad++;
      $display("FAIL reset_state got=%h exp=0", cur_out());
    end
    last   = 13'h0;
    mon_en = 1'b1;
    rst    = 1'b1;
    cyc(2);

    // Start, three rotates, commit, immediate launch, finish.
    start_btn = 1'b1;
    push("idle_to_player", 1, 0, 0, 0, 0, 0);
    cyc(1);
    start_btn = 1'b0;
    rotate_btn = 1'b1;
    push("rot1", 1, 0, 1, 0, 0, 0);
    push("rot2", 1, 0, 2, 0, 0, 0);
    push("rot3", 1, 0, 3, 0, 0, 0);
    cyc(3);
    rotate_btn = 1'b0;
    // Stray pulses in PLAYER must not change anything.
    enemy_finished = 1'b1;
    start_btn      = 1'b1;
    cyc(1);
    {enemy_finished, start_btn} = '0;
    play_turn(0, 3, 0);

    // Busy for 5 cycles in EN_START, then finished coinciding with the 120th frame.
    enemy_busy = 1'b1;
    commit_btn = 1'b1;
    push("commit_busy", 2, 1, 3, 0, 0, 0);
    cyc(1);
    commit_btn = 1'b0;
    cyc(5);
    enemy_busy = 1'b0;
    push("launch_after_busy", 3, 1, 3, 1, 0, 0);
    push("launch_after_busy_end", 3, 1, 3, 0, 0, 0);
    cyc(2);
    for (int i = 0; i < 119; i++) begin
      new_frame = 1'b1;
      cyc(1);
      new_frame = 1'b0;
      cyc(1);
    end
    new_frame      = 1'b1;
    enemy_finished = 1'b1;
    push("finish_beats_timeout", 4, 1, 3, 0, 0, 0);
    push("player_t2", 1, 2, 3, 0, 0, 0);
    cyc(1);
    {new_frame, enemy_finished} = '0;
    cyc(2);

    // Rotate wrap with commit on the same edge; then a watchdog timeout.
    rotate_btn = 1'b1;
    commit_btn = 1'b1;
    push("rot_wrap_commit", 2, 2, 0, 0, 0, 0);
    cyc(1);
    {rotate_btn, commit_btn} = '0;
    push("launch_t2", 3, 2, 0, 1, 0, 0);
    push("launch_t2_end", 3, 2, 0, 0, 0, 0);
    cyc(2);
    for (int i = 0; i < 119; i++) begin
      new_frame = 1'b1;
      cyc(1);
      new_frame = 1'b0;
      cyc(1);
    end
    new_frame = 1'b1;
    push("timeout", 4, 2, 0, 0, 0, 1);
    push("player_t3", 1, 3, 0, 0, 0, 1);
    cyc(1);
    new_frame = 1'b0;
    cyc(2);

    for (int t = 3; t <= 9; t++) play_turn(t, 0, 1);

    // GAME_OVER ignores rotate/commit; start restarts with cleared state.
    rotate_btn = 1'b1;
    commit_btn = 1'b1;
    cyc(1);
    {rotate_btn, commit_btn} = '0;
    cyc(2);
    start_btn = 1'b1;
    push("restart", 1, 0, 0, 0, 0, 0);
    cyc(1);
    start_btn = 1'b0;
    cyc(2);

    // Asynchronous reset in the middle of EN_WAIT.
    commit_btn = 1'b1;
    push("commit_r", 2, 0, 0, 0, 0, 0);
    cyc(1);
    commit_btn = 1'b0;
    push("launch_r", 3, 0, 0, 1, 0, 0);
    push("launch_r_end", 3, 0, 0, 0, 0, 0);
    cyc(3);
    #2;
    push("async_reset", 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    #1;
    total++;
    if (cur_out() !== 13'h0) begin
      bad++;
      $display("FAIL reset_mid_wait got=%h exp=0", cur_out());
    end
    cyc(2);
    rst = 1'b1;
    cyc(4);

`ifdef TURN_TIMER_EN
    start_btn = 1'b1;
    push("tt_player", 1, 0, 0, 0, 0, 0);
    cyc(1);
    start_btn  = 1'b0;
    enemy_busy = 1'b1;
    for (int i = 0; i < 299; i++) begin
      new_frame = 1'b1;
      cyc(1);
      new_frame = 1'b0;
      cyc(1);
    end
    new_frame = 1'b1;
    push("auto_commit", 2, 0, 0, 0, 0, 0);
    cyc(1);
    new_frame  = 1'b0;
    enemy_busy = 1'b0;
    push("tt_launch", 3, 0, 0, 1, 0, 0);
    push("tt_launch_end", 3, 0, 0, 0, 0, 0);
    cyc(3);
`endif

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) cyc(1);
    cyc(2);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL pending_expect got=%0d exp=0 next=%s", exp_q.size(), exp_q[0].name);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
